port_arbiter: RTL and testbench
===============================

PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: flit width in bits on every data port.
REQ-002 Parameter N, default 16: number of NoC nodes.
REQ-003 Parameter N_ADDR_WIDTH, default $clog2(N): router address width.
REQ-004 Parameter NREQ, default 4: number of requesters sharing one router injection port, legal range 2..16.
REQ-005 Parameter LIMIT, default 1000: flit count at which done asserts.
REQ-006 clk  input  1  single clock; every flop is on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  grants are allowed only while en=1.
REQ-009 req_data  input  NREQ x WIDTH  flits from the requesters, in the src/dst/id/data field layout used by the sink.
REQ-010 req_valid  input  NREQ  per-requester valid.
REQ-011 req_ready  output  NREQ  per-requester ready, one-hot or zero.
REQ-012 data_out  output  WIDTH  flit to the router port.
REQ-013 valid_out  output  1  data_out valid.
REQ-014 ready_in  input  1  router port ready.
REQ-015 grant_id  output  $clog2(NREQ)  index of the requester whose flit is held in data_out.
REQ-016 flit_count  output  16  number of flits accepted by the router, saturating.
REQ-017 done  output  1  high when flit_count >= LIMIT.

Function
REQ-018 Two-state FSM: IDLE (output register empty) and HOLD (output register full).
REQ-019 can_load = en AND (state==IDLE OR ready_in).
REQ-020 When can_load=1 and any req_valid=1, the arbiter grants exactly one requester, chosen round-robin starting at index ptr+1 mod NREQ.
REQ-021 req_ready[winner] is combinational in the grant cycle; every other req_ready bit is 0.
REQ-022 On a grant edge, data_out <= req_data[winner], grant_id <= winner, ptr <= winner, and state <= HOLD.
REQ-023 Latency is 1 cycle from grant to valid_out; back-to-back flits sustain one flit per cycle.
REQ-024 In HOLD with ready_in=0: data_out and grant_id stay stable and no grant is issued.
REQ-025 In HOLD with ready_in=1 and no grant: state <= IDLE.
REQ-026 In HOLD with ready_in=1 and a grant: state stays HOLD and the new flit is loaded.
REQ-027 valid_out = (state==HOLD).
REQ-028 flit_count increments on every cycle with valid_out AND ready_in, and saturates at 16'hFFFF.
REQ-029 done is combinational from flit_count.
REQ-030 en=0 stops new grants only; a held flit still drains under the normal handshake.
REQ-031 A requester that deasserts req_valid without being granted loses nothing; ptr is unchanged.
REQ-032 With a single active requester, that requester is granted on every can_load cycle.
REQ-033 The arbiter never inspects or modifies flit contents.

Reset
REQ-034 While rst=0: state=IDLE, ptr=NREQ-1 (so requester 0 has first priority), data_out=0, grant_id=0, flit_count=0, valid_out=0, req_ready=0, done=0.
REQ-035 Reset mid-HOLD discards the held flit; the flit is not counted and is not re-presented.
REQ-036 Reset assertion is asynchronous; deassertion is synchronized externally by the team's standard reset-sync cell.

Structure
REQ-037 The shared NoC package holds: the flit field-position constants (SRC/DST/ID/DATA), the arb_state_t enum, and the counter width.
REQ-038 Grant selection is one sub-module, rr_pick: combinational, inputs req vector and ptr, outputs a one-hot grant, an index, and an any flag.
REQ-039 rr_pick is reusable by other NoC arbiters.

Verification
REQ-040 Scenario: all four req_valid=1 from reset, ready_in=1 -> grant_id sequence 0,1,2,3,0; one valid_out per cycle from cycle 1.
REQ-041 Scenario: only req 2 valid, ready_in=1 for 5 cycles -> five flits, all with grant_id=2, flit_count=5.
REQ-042 Scenario: ready_in=0 for 3 cycles while in HOLD with data A -> data_out=A stable and req_ready=0 throughout; A accepted on the cycle ready_in=1.
REQ-043 Scenario: en dropped in HOLD -> held flit drains, no new grant, state returns to IDLE.
REQ-044 Scenario: LIMIT=8, continuous traffic -> done rises on the cycle after the 8th accepted flit.
REQ-045 Scenario: rst pulsed while in HOLD -> valid_out=0 immediately; the next grant goes to req 0.

Source files
------------

// File: rtl/port_arbiter_pkg.sv
// Shared NoC definitions for the port arbiter and related blocks.
//   - flit field positions (src / dst / id / data) for the default
//     16-node, 32-bit flit layout
//   - arb_state_t: output-register state of an injection-port arbiter
//   - CNT_W: width of the accepted-flit counter
//   - small field-extraction helpers for sinks and monitors
package port_arbiter_pkg;

    localparam int CNT_W    = 16;

    localparam int SRC_LSB  = 0;
    localparam int SRC_W    = 4;
    localparam int DST_LSB  = 4;
    localparam int DST_W    = 4;
    localparam int ID_LSB   = 8;
    localparam int ID_W     = 8;
    localparam int DATA_LSB = 16;
    localparam int DATA_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,   // output register empty
        HOLD = 1'b1    // output register holds a flit
    } arb_state_t;

    function automatic logic [SRC_W-1:0] flit_src(input logic [31:0] flit);
        return flit[SRC_LSB +: SRC_W];
    endfunction

    function automatic logic [DST_W-1:0] flit_dst(input logic [31:0] flit);
        return flit[DST_LSB +: DST_W];
    endfunction

    function automatic logic [ID_W-1:0] flit_id(input logic [31:0] flit);
        return flit[ID_LSB +: ID_W];
    endfunction

    function automatic logic [DATA_W-1:0] flit_data(input logic [31:0] flit);
        return flit[DATA_LSB +: DATA_W];
    endfunction

endpackage

// File: rtl/port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, reusable by any NoC arbiter.
// Search starts at ptr+1 (mod NREQ) and wraps, so the last winner has the
// lowest priority on the next pick.
//   req   : request vector
//   ptr   : index of the previous winner
//   grant : one-hot grant (zero when no request)
//   idx   : index of the granted requester (zero when no request)
//   any   : at least one request present
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: shares one router injection port between NREQ requesters.
// A single output register holds the granted flit; a new flit may be loaded
// whenever the register is empty or is being drained in the same cycle, so
// back-to-back traffic runs at one flit per cycle.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   en         : allows new grants (a held flit drains regardless)
//   req_data   : per-requester flits
//   req_valid  : per-requester valid
//   req_ready  : per-requester ready, one-hot or zero, combinational
//   data_out   : held flit towards the router
//   valid_out  : data_out valid
//   ready_in   : router accepts data_out
//   grant_id   : requester index of the held flit
//   flit_count : flits accepted by the router, saturating
//   done       : flit_count >= LIMIT
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NREQ         = 4,
    parameter int LIMIT        = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_data,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    output logic [WIDTH-1:0]            data_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [$clog2(NREQ)-1:0]     grant_id,
    output logic [CNT_W-1:0]            flit_count,
    output logic                        done
);

    localparam int GW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 16 || N_ADDR_WIDTH < $clog2(N)) begin : g_param_check
        $error("port_arbiter: illegal parameterisation");
    end

    arb_state_t     state;
    logic [GW-1:0]  ptr;

    logic [NREQ-1:0] pick_grant;
    logic [GW-1:0]   pick_idx;
    logic            pick_any;
    logic            can_load;
    logic            do_grant;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // rst gates the grant so req_ready stays low for the whole reset period.
    assign can_load  = en && (state == IDLE || ready_in);
    assign do_grant  = rst && can_load && pick_any;
    assign req_ready = do_grant ? pick_grant : '0;
    assign valid_out = (state == HOLD);
    assign done      = 32'(flit_count) >= LIMIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= GW'(NREQ - 1);
            data_out <= '0;
            grant_id <= '0;
        end else if (do_grant) begin
            data_out <= req_data[pick_idx];
            grant_id <= pick_idx;
            ptr      <= pick_idx;
            state    <= HOLD;
        end else if (state == HOLD && ready_in) begin
            state    <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_count <= '0;
        end else if (valid_out && ready_in && flit_count != '1) begin
            flit_count <= flit_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_port_arbiter.sv
module tb_port_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int LIMIT = 8;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       en;
    logic [NREQ-1:0][WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [WIDTH-1:0]           data_out;
    logic                       valid_out;
    logic                       ready_in;
    logic [1:0]                 grant_id;
    logic [15:0]                flit_count;
    logic                       done;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    port_arbiter #(
        .WIDTH (WIDTH),
        .N     (16),
        .NREQ  (NREQ),
        .LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .grant_id   (grant_id),
        .flit_count (flit_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkflit(input int scn, input int k, input int i);
        return {8'(scn), 8'(k), 8'(i), 8'hA5};
    endfunction

    function automatic exp_t mkexp(input int id, input logic [31:0] data);
        exp_t e;
        e.id   = 2'(id);
        e.data = data;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        en        = 1'b1;
        ready_in  = 1'b1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Monitor: every accepted flit must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_unexpected: got id %0d data %0h, expected no flit", grant_id, data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_grant_id", 64'(grant_id), 64'(e.id));
                chk("mon_data_out", 64'(data_out), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        ready_in  = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_data[i] = mkflit(1, 0, i);
        tick();
        tick();

        // Reset state, with every input pushing for a grant
        @(negedge clk);
        chk("rst_req_ready",  64'(req_ready),  64'h0);
        chk("rst_valid_out",  64'(valid_out),  64'h0);
        chk("rst_data_out",   64'(data_out),   64'h0);
        chk("rst_grant_id",   64'(grant_id),   64'h0);
        chk("rst_flit_count", 64'(flit_count), 64'h0);
        chk("rst_done",       64'(done),       64'h0);
        tick();
        rst = 1'b1;

        // Scenario 1: all requesters valid -> 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("s1_req_ready", 64'(req_ready), 64'(1 << (k % 4)));
            if (k > 0) chk("s1_valid_out", 64'(valid_out), 64'h1);
            sb.push_back(mkexp(k % 4, mkflit(1, 0, k % 4)));
            tick();
        end
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("s1_idle_valid", 64'(valid_out),  64'h0);
        chk("s1_flit_count", 64'(flit_count), 64'd5);

        // Scenario 2: only requester 2, fresh data every cycle
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req_data[2] = mkflit(2, k, 2);
            req_valid   = 4'b0100;
            @(negedge clk);
            chk("s2_req_ready", 64'(req_ready), 64'h4);
            sb.push_back(mkexp(2, mkflit(2, k, 2)));
            tick();
        end
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("s2_flit_count", 64'(flit_count), 64'd5);
        chk("s2_done",       64'(done),       64'h0);

        // Scenario 3: router stalls 3 cycles on flit A
        do_reset();
        ready_in    = 1'b0;
        req_valid   = 4'b0010;
        req_data[1] = mkflit(3, 0, 1);
        @(negedge clk);
        chk("s3_grant_idle", 64'(req_ready), 64'h2);
        sb.push_back(mkexp(1, mkflit(3, 0, 1)));
        tick();
        req_data[1] = mkflit(3, 1, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s3_stall_data",  64'(data_out),  64'(mkflit(3, 0, 1)));
            chk("s3_stall_id",    64'(grant_id),  64'h1);
            chk("s3_stall_ready", 64'(req_ready), 64'h0);
            chk("s3_stall_valid", 64'(valid_out), 64'h1);
            tick();
        end
        ready_in = 1'b1;
        @(negedge clk);
        chk("s3_reload_ready", 64'(req_ready), 64'h2);
        sb.push_back(mkexp(1, mkflit(3, 1, 1)));
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("s3_flit_count", 64'(flit_count), 64'd2);
        chk("s3_idle_valid", 64'(valid_out),  64'h0);

        // Scenario 4: en dropped while holding
        do_reset();
        ready_in    = 1'b0;
        req_valid   = 4'b0001;
        req_data[0] = mkflit(4, 0, 0);
        @(negedge clk);
        chk("s4_grant", 64'(req_ready), 64'h1);
        sb.push_back(mkexp(0, mkflit(4, 0, 0)));
        tick();
        en = 1'b0;
        @(negedge clk);
        chk("s4_hold_ready", 64'(req_ready), 64'h0);
        chk("s4_hold_valid", 64'(valid_out), 64'h1);
        tick();
        ready_in = 1'b1;
        @(negedge clk);
        chk("s4_drain_ready", 64'(req_ready), 64'h0);
        tick();
        @(negedge clk);
        chk("s4_idle_valid", 64'(valid_out),  64'h0);
        chk("s4_idle_ready", 64'(req_ready),  64'h0);
        chk("s4_flit_count", 64'(flit_count), 64'd1);
        en        = 1'b1;
        req_valid = '0;

        // Scenario 5: continuous traffic, done after the 8th accept
        do_reset();
        for (int i = 0; i < NREQ; i++) req_data[i] = mkflit(5, 0, i);
        req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sb.push_back(mkexp(k % 4, mkflit(5, 0, k % 4)));
            if (k == 8) begin
                chk("s5_count_7", 64'(flit_count), 64'd7);
                chk("s5_done_lo", 64'(done),       64'h0);
            end
            if (k == 9) begin
                chk("s5_count_8", 64'(flit_count), 64'd8);
                chk("s5_done_hi", 64'(done),       64'h1);
            end
            tick();
        end
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("s5_flit_count", 64'(flit_count), 64'd10);

        // Scenario 6: reset pulsed while holding a flit from requester 1
        do_reset();
        ready_in    = 1'b0;
        req_valid   = 4'b0010;
        req_data[1] = mkflit(6, 0, 1);
        @(negedge clk);
        chk("s6_grant1", 64'(req_ready), 64'h2);
        tick();
        rst = 1'b0;
        #1;
        chk("s6_async_valid", 64'(valid_out), 64'h0);
        @(negedge clk);
        chk("s6_rst_data",  64'(data_out),   64'h0);
        chk("s6_rst_count", 64'(flit_count), 64'h0);
        tick();
        rst       = 1'b1;
        ready_in  = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_data[i] = mkflit(6, 1, i);
        @(negedge clk);
        chk("s6_first_after_rst", 64'(req_ready), 64'h1);
        sb.push_back(mkexp(0, mkflit(6, 1, 0)));
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("s6_flit_count", 64'(flit_count), 64'd1);

        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
